// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth product accumulator.
package booth_pkg;

  // Accumulator FSM: collect terms, then hold the closed result until taken.
  typedef enum logic [0:0] {
    StAccum = 1'b0,
    StDrain = 1'b1
  } acc_state_e;

  localparam int unsigned DefProdW    = 8;
  localparam int unsigned DefAccW     = 16;
  localparam int unsigned DefMaxTerms = 16;

  // Term counter must be able to hold MAX_TERMS itself, not just MAX_TERMS-1.
  function automatic int unsigned cnt_width(input int unsigned max_terms);
    return $clog2(max_terms) + 1;
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Signed accumulate adder: ACC_W accumulator plus sign-extended PROD_W product.
// Build option BOOTH_ACC_SAT_EN clamps the sum on overflow; otherwise it wraps.
module booth_sat_add #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   full_sum;

  assign prod_ext = {{(ACC_W - PROD_W){prod_i[PROD_W-1]}}, prod_i};
  assign full_sum = {acc_i[ACC_W-1], acc_i} + {prod_ext[ACC_W-1], prod_ext};

  // With a full-precision sum, "operand signs agree but result sign differs"
  // is the same as the top two bits of the ACC_W+1 result disagreeing.
  assign ovf_o = full_sum[ACC_W] ^ full_sum[ACC_W-1];

  // Select the stored sum; full_sum[ACC_W] is the true sign of the result.
  always_comb begin
`ifdef BOOTH_ACC_SAT_EN
    if (ovf_o) begin
      sum_o = full_sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end else begin
      sum_o = full_sum[ACC_W-1:0];
    end
`else
    sum_o = full_sum[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// MAC back end for the 4x4 Booth multiplier: accumulates a signed product
// stream into one result per in_last (or per MAX_TERMS terms) and holds the
// result on a valid/ready port. Optional build macro: BOOTH_ACC_SAT_EN
// (saturating accumulator instead of wrapping).
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned PROD_W    = DefProdW,
  parameter int unsigned ACC_W     = DefAccW,
  parameter int unsigned MAX_TERMS = DefMaxTerms
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ena,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PROD_W-1:0]                 in_product,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_W-1:0]                  acc_out,
  output logic [cnt_width(MAX_TERMS)-1:0]   term_count,
  output logic                              overflow
);

  localparam int unsigned CntW = cnt_width(MAX_TERMS);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CntW-1:0]  cnt_inc;
  logic             accept;

  booth_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc_i  (acc_q),
    .prod_i (in_product),
    .sum_o  (add_sum),
    .ovf_o  (add_ovf)
  );

  // in_ready depends on state and ena only, never on in_valid.
  assign in_ready  = (state_q == StAccum) & ena;
  assign accept    = in_valid & in_ready;
  assign cnt_inc   = cnt_q + 1'b1;

  assign out_valid  = (state_q == StDrain);
  assign acc_out    = acc_q;
  assign term_count = cnt_q;
  assign overflow   = ovf_q;

  // Next-state: accumulate in StAccum, clear everything on the output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StAccum: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
          if (in_last || (cnt_inc == CntW'(MAX_TERMS))) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_ready) begin
          state_d = StAccum;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  // State registers; asynchronous reset discards any partial result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
